multicycle_control_fsm: RTL

//  Multi-cycle sequencer for the 16-bit datapath. It replaces the single-cycle decoder and fetches through an

---
 rtl/multicycle_control_fsm.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control sequencer for the 16-bit datapath: fetch handshake, decode,
// EXEC/MEM/WB stepping, memory timeout trap, debug halt and retired-instruction count.
module multicycle_control_fsm #(
  parameter int MEM_TIMEOUT = 15,
  parameter int RETIRE_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3:0]          opcode,
  input  logic                imem_ack,
  input  logic                dmem_ack,
  input  logic                stall_req,
  input  logic                resume,
  output logic                imem_req,
  output logic                ir_write,
  output logic                pc_en,
  output logic                jump,
  output logic                beq,
  output logic                bne,
  output logic                mem_read,
  output logic                mem_write,
  output logic                alu_src,
  output logic                reg_dst,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic [1:0]          alu_op,
  output logic [2:0]          state,
  output logic                halted,
  output logic                trap,
  output logic [RETIRE_W-1:0] retired_cnt
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_TRAP   = 3'd6;

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  logic [2:0]          r_state;
  logic [3:0]          r_op;
  logic [7:0]          r_tmo;
  logic [RETIRE_W-1:0] r_retired;

  logic [2:0] w_state_next;
  logic [2:0] w_boundary;
  logic       w_lw, w_sw, w_rtype, w_addi, w_beq, w_bne, w_j, w_branch;
  logic       w_ctl_active;
  logic       w_pc_en;
  logic       w_run;

  assign w_lw     = (r_op == 4'd0);
  assign w_sw     = (r_op == 4'd1);
  assign w_rtype  = (r_op >= 4'd2) && (r_op <= 4'd9);
  assign w_addi   = (r_op == 4'd10);
  assign w_beq    = (r_op == 4'd11);
  assign w_bne    = (r_op == 4'd12);
  assign w_j      = (r_op == 4'd13);
  assign w_branch = w_beq | w_bne | w_j;

  // A debug halt request diverts the return to FETCH into HALT.
  assign w_boundary = stall_req ? S_HALT : S_FETCH;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (imem_ack)              w_state_next = S_DECODE;
        else if (r_tmo >= TMO_LAST) w_state_next = S_TRAP;
      end
      S_DECODE: begin
        if (opcode == 4'd14)      w_state_next = S_TRAP;
        else if (opcode == 4'd15) w_state_next = S_HALT;
        else                      w_state_next = S_EXEC;
      end
      S_EXEC: begin
        if (w_branch)           w_state_next = w_boundary;
        else if (w_lw || w_sw)  w_state_next = S_MEM;
        else                    w_state_next = S_WB;
      end
      S_MEM: begin
        if (dmem_ack)               w_state_next = w_lw ? S_WB : w_boundary;
        else if (r_tmo >= TMO_LAST) w_state_next = S_TRAP;
      end
      S_WB:    w_state_next = w_boundary;
      S_HALT:  if (resume) w_state_next = S_FETCH;
      S_TRAP:  w_state_next = S_TRAP;
      default: w_state_next = S_FETCH;
    endcase
  end

  assign w_pc_en = ((r_state == S_EXEC) && w_branch) ||
                   ((r_state == S_MEM) && w_sw && dmem_ack) ||
                   (r_state == S_WB);

  // The timeout counter only matters while waiting in FETCH/MEM, so any
  // state change may clear it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_FETCH;
      r_op      <= 4'd0;
      r_tmo     <= 8'd0;
      r_retired <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_DECODE) r_op <= opcode;
      if (w_state_next != r_state)                        r_tmo <= 8'd0;
      else if ((r_state == S_FETCH) || (r_state == S_MEM)) r_tmo <= r_tmo + 8'd1;
      if (w_pc_en) r_retired <= r_retired + {{(RETIRE_W-1){1'b0}}, 1'b1};
    end
  end

  assign w_run        = ~rst;
  assign w_ctl_active = (r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB);

  assign imem_req   = w_run & (r_state == S_FETCH);
  assign ir_write   = w_run & (r_state == S_FETCH) & imem_ack;
  assign pc_en      = w_run & w_pc_en;
  assign jump       = w_run & (r_state == S_EXEC) & w_j;
  assign beq        = w_run & (r_state == S_EXEC) & w_beq;
  assign bne        = w_run & (r_state == S_EXEC) & w_bne;
  assign mem_read   = w_run & (r_state == S_MEM) & w_lw;
  assign mem_write  = w_run & (r_state == S_MEM) & w_sw;
  assign reg_write  = w_run & (r_state == S_WB);
  assign alu_src    = w_run & w_ctl_active & (w_lw | w_sw | w_addi);
  assign reg_dst    = w_run & w_ctl_active & w_rtype;
  assign mem_to_reg = w_run & w_ctl_active & w_lw;

  always_comb begin
    alu_op = 2'b00;
    if (w_run && w_ctl_active) begin
      if (w_lw || w_sw)         alu_op = 2'b10;
      else if (w_addi)          alu_op = 2'b11;
      else if (w_beq || w_bne)  alu_op = 2'b01;
    end
  end

  assign state       = w_run ? r_state : S_FETCH;
  assign halted      = w_run & (r_state == S_HALT);
  assign trap        = w_run & (r_state == S_TRAP);
  assign retired_cnt = w_run ? r_retired : '0;

endmodule
